// File: rtl/watch_chain_reader.sv
// Debugger-side reader for the CPU watch scan chains: captures the selected chain,
// shifts it out with a generated scan clock and streams it LSB-first as bytes.
module watch_chain_reader #(
    parameter int CHAIN1_LEN = 382,
    parameter int CHAIN2_LEN = 9,
    parameter int TCK_DIV    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       iStart,
    input  logic       iSel,
    output logic       oBusy,
    output logic       oDone,
    output logic       oScanClk,
    output logic       oScanIn,
    output logic [1:0] oScanCtrl1,
    output logic [1:0] oScanCtrl2,
    input  logic       iScanOut1,
    input  logic       iScanOut2,
    output logic [7:0] oData,
    output logic       oValid,
    input  logic       iReady
);

    localparam int MAX_LEN = (CHAIN1_LEN > CHAIN2_LEN) ? CHAIN1_LEN : CHAIN2_LEN;
    localparam int CNT_W   = ($clog2(MAX_LEN + 1) > 3) ? $clog2(MAX_LEN + 1) : 3;
    localparam int TMR_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    localparam logic [CNT_W-1:0] LEN1     = CNT_W'(CHAIN1_LEN);
    localparam logic [CNT_W-1:0] LEN2     = CNT_W'(CHAIN2_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TCK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAP_LO,
        CAP_HI,
        SH_LO,
        SH_HI,
        PUSH,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [CNT_W-1:0] bitcnt, bitcnt_n;
    logic [CNT_W-1:0] len;
    logic [7:0]       asm_q, asm_n;
    logic             sel, sel_n;
    logic             scan_bit;
    logic             phase_end;
    logic [1:0]       ctrl_n;

    assign len       = sel ? LEN2 : LEN1;
    assign scan_bit  = sel ? iScanOut2 : iScanOut1;
    assign phase_end = (timer == TMR_LAST);

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        bitcnt_n = bitcnt;
        asm_n    = asm_q;
        sel_n    = sel;
        case (state)
            IDLE: begin
                if (iStart) begin
                    sel_n    = iSel;
                    bitcnt_n = '0;
                    asm_n    = '0;
                    timer_n  = '0;
                    state_n  = CAP_LO;
                end
            end
            CAP_LO: begin
                if (phase_end) begin
                    timer_n = '0;
                    state_n = CAP_HI;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            CAP_HI: begin
                if (phase_end) begin
                    timer_n = '0;
                    state_n = SH_LO;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            SH_LO: begin
                // Sample at the end of the low phase, just before the shifting rise.
                if (phase_end) begin
                    timer_n                = '0;
                    asm_n[bitcnt[2:0]]     = scan_bit;
                    bitcnt_n               = bitcnt + 1'b1;
                    if ((bitcnt_n[2:0] == 3'd0) || (bitcnt_n == len)) begin
                        state_n = PUSH;
                    end else begin
                        state_n = SH_HI;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            SH_HI: begin
                if (phase_end) begin
                    timer_n = '0;
                    state_n = SH_LO;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            PUSH: begin
                if (iReady) begin
                    asm_n   = '0;
                    state_n = (bitcnt == len) ? DONE : SH_HI;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so every pin comes straight off a flop.
    always_comb begin
        ctrl_n = 2'b00;
        case (state_n)
            CAP_LO, CAP_HI:    ctrl_n = 2'b01;
            SH_LO, SH_HI, PUSH: ctrl_n = 2'b10;
            default:           ctrl_n = 2'b00;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            timer      <= '0;
            bitcnt     <= '0;
            asm_q      <= '0;
            sel        <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oScanClk   <= 1'b0;
            oScanCtrl1 <= 2'b00;
            oScanCtrl2 <= 2'b00;
            oValid     <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bitcnt     <= bitcnt_n;
            asm_q      <= asm_n;
            sel        <= sel_n;
            oBusy      <= (state_n != IDLE);
            oDone      <= (state_n == DONE);
            oScanClk   <= (state_n == CAP_HI) || (state_n == SH_HI);
            oScanCtrl1 <= sel_n ? 2'b00 : ctrl_n;
            oScanCtrl2 <= sel_n ? ctrl_n : 2'b00;
            oValid     <= (state_n == PUSH);
        end
    end

    assign oData   = asm_q;
    assign oScanIn = 1'b0;

endmodule

// File: tb/tb_watch_chain_reader.sv
// Bench for watch_chain_reader: two instances (12/9 bits at TCK_DIV=1, 16/9 bits at
// TCK_DIV=2) driven against behavioural scan chains, with a byte scoreboard.
module tb_watch_chain_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, sel_a, ready_a, busy_a, done_a, sck_a, sin_a, so1_a, so2_a, valid_a;
    logic [1:0] c1_a, c2_a;
    logic [7:0] data_a;
    logic       rst_b, start_b, sel_b, ready_b, busy_b, done_b, sck_b, sin_b, so1_b, so2_b, valid_b;
    logic [1:0] c1_b, c2_b;
    logic [7:0] data_b;

    int checks   = 0;
    int failures = 0;

    watch_chain_reader #(.CHAIN1_LEN(12), .CHAIN2_LEN(9), .TCK_DIV(1)) dut_a (
        .Clk(clk), .Reset(rst_a), .iStart(start_a), .iSel(sel_a), .oBusy(busy_a),
        .oDone(done_a), .oScanClk(sck_a), .oScanIn(sin_a), .oScanCtrl1(c1_a),
        .oScanCtrl2(c2_a), .iScanOut1(so1_a), .iScanOut2(so2_a), .oData(data_a),
        .oValid(valid_a), .iReady(ready_a)
    );

    watch_chain_reader #(.CHAIN1_LEN(16), .CHAIN2_LEN(9), .TCK_DIV(2)) dut_b (
        .Clk(clk), .Reset(rst_b), .iStart(start_b), .iSel(sel_b), .oBusy(busy_b),
        .oDone(done_b), .oScanClk(sck_b), .oScanIn(sin_b), .oScanCtrl1(c1_b),
        .oScanCtrl2(c2_b), .iScanOut1(so1_b), .iScanOut2(so2_b), .oData(data_b),
        .oValid(valid_b), .iReady(ready_b)
    );

    // Behavioural chains: capture on a TCK rise with CaptureDR, shift right with ShiftDR.
    logic [15:0] ch1_a, ch2_a, cap1_a, cap2_a;
    logic [15:0] ch1_b, ch2_b, cap1_b, cap2_b;
    int ncap_a = 0, nsh_a = 0, ncap_b = 0, nsh_b = 0;

    always @(posedge sck_a) begin
        if (c1_a[0]) ch1_a <= cap1_a; else if (c1_a[1]) ch1_a <= ch1_a >> 1;
        if (c2_a[0]) ch2_a <= cap2_a; else if (c2_a[1]) ch2_a <= ch2_a >> 1;
        if (c1_a[0] | c2_a[0]) ncap_a <= ncap_a + 1;
        if (c1_a[1] | c2_a[1]) nsh_a <= nsh_a + 1;
    end

    always @(posedge sck_b) begin
        if (c1_b[0]) ch1_b <= cap1_b; else if (c1_b[1]) ch1_b <= ch1_b >> 1;
        if (c2_b[0]) ch2_b <= cap2_b; else if (c2_b[1]) ch2_b <= ch2_b >> 1;
        if (c1_b[0] | c2_b[0]) ncap_b <= ncap_b + 1;
        if (c1_b[1] | c2_b[1]) nsh_b <= nsh_b + 1;
    end

    assign so1_a = ch1_a[0];
    assign so2_a = ch2_a[0];
    assign so1_b = ch1_b[0];
    assign so2_b = ch2_b[0];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_a();
        return 32'({busy_a, done_a, sck_a, sin_a, c1_a, c2_a, data_a, valid_a});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({busy_b, done_b, sck_b, sin_b, c1_b, c2_b, data_b, valid_b});
    endfunction

    // Scoreboard and monitor
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] mon_e;
    int  ndone_a = 0, ndone_b = 0, nidle_a = 0, nc2_a = 0, nc1_b = 0;
    bit  prev_busy_a = 1'b0, prev_sck_b = 1'b0;
    int  hi_run = 0, lo_run = 0;

    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            check("a_byte_pending", 32'(exp_a.size() > 0), 32'd1);
            if (exp_a.size() > 0) begin
                mon_e = exp_a.pop_front();
                check("a_byte", 32'(data_a), 32'(mon_e));
            end
        end
        if (valid_b && ready_b) begin
            check("b_byte_pending", 32'(exp_b.size() > 0), 32'd1);
            if (exp_b.size() > 0) begin
                mon_e = exp_b.pop_front();
                check("b_byte", 32'(data_b), 32'(mon_e));
            end
        end
        if (done_a) ndone_a++;
        if (done_b) ndone_b++;
        if (c2_a != 2'b00) nc2_a++;
        if (c1_b != 2'b00) nc1_b++;
        if (prev_busy_a && !busy_a) nidle_a++;
        prev_busy_a = busy_a;
        // TCK phase widths on instance b; PUSH cycles are excluded from the low phase.
        if (!busy_b) begin
            hi_run = 0;
            lo_run = 0;
            prev_sck_b = 1'b0;
        end else if (sck_b) begin
            if (!prev_sck_b) begin
                check("b_tck_low_cycles", 32'(lo_run), 32'd2);
                lo_run = 0;
            end
            hi_run++;
            prev_sck_b = 1'b1;
        end else begin
            if (prev_sck_b) begin
                check("b_tck_high_cycles", 32'(hi_run), 32'd2);
                hi_run = 0;
            end
            if (!valid_b) lo_run++;
            prev_sck_b = 1'b0;
        end
    end

    // Returns one cycle after the accepting edge (cycle 1 of the read).
    task automatic start_read(input int inst, input logic s);
        @(posedge clk); #1;
        if (inst == 0) begin start_a = 1'b1; sel_a = s; end
        else           begin start_b = 1'b1; sel_b = s; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (inst == 0) sel_a = ~s; else sel_b = ~s;
    endtask

    task automatic wait_done(input string name, input int inst, input int first, output int cyc);
        cyc = first;
        while (!((inst == 0) ? done_a : done_b) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!((inst == 0) ? done_a : done_b)) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout: got=no_done expected=done", name);
        end
    endtask

    logic [7:0] exp_bytes [2];
    int cyc, n, b_cap, b_sh, b_done, b_c, b_idle, snap;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1;
        cap1_a = 16'h0; cap2_a = 16'h0; cap1_b = 16'h0; cap2_b = 16'h0;
        #2;
        check("a_reset_outputs", outs_a(), 32'd0);
        check("b_reset_outputs", outs_b(), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("a_idle_outputs", outs_a(), 32'd0);
        check("b_idle_outputs", outs_b(), 32'd0);

        // Chain 1 basic read on a: 12'hABC, chain 2 holds a decoy value.
        cap1_a = 16'h0ABC; cap2_a = 16'h0155;
        exp_a.push_back(8'hBC); exp_a.push_back(8'h0A);
        b_cap = ncap_a; b_sh = nsh_a; b_done = ndone_a; b_c = nc2_a;
        start_read(0, 1'b0);
        wait_done("a_basic", 0, 1, cyc);
        check("a_basic_done_cycle", 32'(cyc), 32'd28);
        check("a_basic_capture_edges", 32'(ncap_a - b_cap), 32'd1);
        check("a_basic_shift_edges", 32'(nsh_a - b_sh), 32'd11);
        repeat (2) @(posedge clk); #1;
        check("a_basic_ctrl2_quiet", 32'(nc2_a - b_c), 32'd0);
        check("a_basic_bytes_left", 32'(exp_a.size()), 32'd0);
        check("a_basic_done_pulses", 32'(ndone_a - b_done), 32'd1);

        // Chain 2 read on b at TCK_DIV=2: 9'h1A5.
        cap1_b = 16'hFFFF; cap2_b = 16'h01A5;
        exp_b.push_back(8'hA5); exp_b.push_back(8'h01);
        b_done = ndone_b; b_c = nc1_b;
        start_read(1, 1'b1);
        wait_done("b_chain2", 1, 1, cyc);
        check("b_chain2_done_cycle", 32'(cyc), 32'd41);
        repeat (2) @(posedge clk); #1;
        check("b_chain2_ctrl1_quiet", 32'(nc1_b - b_c), 32'd0);
        check("b_chain2_bytes_left", 32'(exp_b.size()), 32'd0);
        check("b_chain2_done_pulses", 32'(ndone_b - b_done), 32'd1);

        // Backpressure on a: 10 stalled cycles at each PUSH.
        exp_bytes[0] = 8'hBC; exp_bytes[1] = 8'h0A;
        exp_a.push_back(8'hBC); exp_a.push_back(8'h0A);
        ready_a = 1'b0;
        b_done = ndone_a;
        start_read(0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (!valid_a && n < 200) begin @(negedge clk); n++; end
            check("a_stall_valid_seen", 32'(valid_a), 32'd1);
            snap = nsh_a;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check("a_stall_hold", 32'({valid_a, data_a, sck_a}), 32'({1'b1, exp_bytes[i], 1'b0}));
            end
            check("a_stall_no_tck_edges", 32'(nsh_a - snap), 32'd0);
            @(posedge clk); #1 ready_a = 1'b1;
            @(posedge clk); #1 ready_a = 1'b0;
        end
        wait_done("a_stall", 0, 1, cyc);
        ready_a = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("a_stall_bytes_left", 32'(exp_a.size()), 32'd0);
        check("a_stall_done_pulses", 32'(ndone_a - b_done), 32'd1);

        // Asynchronous reset during the 5th shifting TCK high phase.
        b_sh = nsh_a; b_done = ndone_a;
        start_read(0, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while ((nsh_a - b_sh) < 5 && n < 100);
        check("a_fifth_shift_high", 32'({sck_a, c1_a}), 32'b110);
        rst_a = 1'b1;
        #1;
        check("a_async_reset_outputs", outs_a(), 32'd0);
        @(posedge clk); #1 rst_a = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("a_abort_no_done", 32'(ndone_a - b_done), 32'd0);
        check("a_abort_idle", 32'(busy_a), 32'd0);
        exp_a.push_back(8'hBC); exp_a.push_back(8'h0A);
        start_read(0, 1'b0);
        wait_done("a_after_reset", 0, 1, cyc);
        check("a_after_reset_done_cycle", 32'(cyc), 32'd28);
        repeat (2) @(posedge clk); #1;
        check("a_after_reset_bytes_left", 32'(exp_a.size()), 32'd0);

        // Start pulse with iSel flipped while busy must be ignored.
        exp_a.push_back(8'hBC); exp_a.push_back(8'h0A);
        b_done = ndone_a; b_idle = nidle_a; b_c = nc2_a;
        start_read(0, 1'b0);
        repeat (6) @(posedge clk);
        #1 start_a = 1'b1; sel_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done("a_ignored_start", 0, 8, cyc);
        check("a_ignored_start_done_cycle", 32'(cyc), 32'd28);
        repeat (20) @(posedge clk); #1;
        check("a_ignored_start_done_pulses", 32'(ndone_a - b_done), 32'd1);
        check("a_ignored_start_idle_entries", 32'(nidle_a - b_idle), 32'd1);
        check("a_ignored_start_ctrl2_quiet", 32'(nc2_a - b_c), 32'd0);
        check("a_ignored_start_bytes_left", 32'(exp_a.size()), 32'd0);

        // Byte-aligned 16-bit chain on b: exactly two full bytes.
        cap1_b = 16'h1234; cap2_b = 16'h00FF;
        exp_b.push_back(8'h34); exp_b.push_back(8'h12);
        b_done = ndone_b;
        start_read(1, 1'b0);
        wait_done("b_aligned", 1, 1, cyc);
        check("b_aligned_done_cycle", 32'(cyc), 32'd69);
        repeat (3) @(posedge clk); #1;
        check("b_aligned_bytes_left", 32'(exp_b.size()), 32'd0);
        check("b_aligned_done_pulses", 32'(ndone_b - b_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
